// File: rtl/conv_job_loader.sv
// conv_job_loader: loads a framed matrix stream into input SRAM from address 0,
// then starts the convolution engine and follows its dut_run/dut_busy handshake.
module conv_job_loader #(
   parameter int unsigned       ADDR_W       = 12,
   parameter int unsigned       DATA_W       = 16,
   parameter logic [DATA_W-1:0] END_MARK     = 16'h00FF,
   parameter int unsigned       MAX_DIM      = 16,
   parameter int unsigned       BUSY_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] host_sram_write_address,
   output logic [DATA_W-1:0] host_sram_write_data,
   output logic              host_sram_write_enable,
   output logic              dut_run,
   input  logic              dut_busy,
   output logic [7:0]        job_count,
   output logic              run_done,
   output logic              error
);
   localparam int unsigned DIM_W = $clog2(MAX_DIM + 1);
   localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);
   localparam int unsigned JOB_W = 8;

   typedef enum logic [3:0] {
      IDLE, NROWS, NCOLS, DATA, RUN, WAIT_BUSY, WAIT_DONE, DONE, ERR
   } state_t;

   state_t            state, next_state;
   logic [ADDR_W-1:0] ptr, ptr_d;
   logic [DIM_W-1:0]  nrows, nrows_d, row, row_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [JOB_W-1:0]  job_d;
   logic              wr_d, accept, dim_ok, ptr_full;

   // Next-state, next-register and stream handshake logic
   always_comb begin
      next_state = state;
      ptr_d      = ptr;
      nrows_d    = nrows;
      row_d      = row;
      cnt_d      = cnt;
      job_d      = job_count;
      wr_d       = 1'b0;
      in_ready   = (state == NROWS) || (state == NCOLS) || (state == DATA);
      accept     = in_valid && in_ready;
      dim_ok     = (in_data != '0) && (in_data <= DATA_W'(MAX_DIM));
      ptr_full   = (ptr == {ADDR_W{1'b1}});

      case (state)
         IDLE, DONE, ERR: begin
            if (start) begin
               next_state = NROWS;
               ptr_d      = '0;
               job_d      = '0;
            end
         end
         NROWS: begin
            if (accept) begin
               if (in_data == END_MARK) begin
                  wr_d       = 1'b1;
                  next_state = RUN;
               end else if (!dim_ok) begin
                  next_state = ERR;
               end else begin
                  wr_d       = 1'b1;
                  nrows_d    = DIM_W'(in_data);
                  next_state = NCOLS;
               end
            end
         end
         NCOLS: begin
            if (accept) begin
               if (dim_ok) begin
                  wr_d       = 1'b1;
                  row_d      = '0;
                  next_state = DATA;
               end else begin
                  next_state = ERR;
               end
            end
         end
         DATA: begin
            if (accept) begin
               wr_d = 1'b1;
               if (row == nrows - DIM_W'(1)) begin
                  if (job_count != {JOB_W{1'b1}}) job_d = job_count + JOB_W'(1);
                  next_state = NROWS;
               end else begin
                  row_d = row + DIM_W'(1);
               end
            end
         end
         RUN: begin
            cnt_d      = '0;
            next_state = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (dut_busy)                              next_state = WAIT_DONE;
            else if (cnt == CNT_W'(BUSY_TIMEOUT - 1))  next_state = ERR;
            else                                       cnt_d = cnt + CNT_W'(1);
         end
         WAIT_DONE: begin
            if (!dut_busy) next_state = DONE;
         end
         default: next_state = IDLE;
      endcase

      // The last SRAM location is written but the pointer saturates there
      if (wr_d && !ptr_full) ptr_d = ptr + ADDR_W'(1);
      if (wr_d && ptr_full && next_state != RUN) next_state = ERR;
   end

   always_ff @(posedge clk) begin
      if (reset_b) begin
         state                   <= IDLE;
         ptr                     <= '0;
         nrows                   <= '0;
         row                     <= '0;
         cnt                     <= '0;
         job_count               <= '0;
         host_sram_write_enable  <= 1'b0;
         host_sram_write_address <= '0;
         host_sram_write_data    <= '0;
         dut_run                 <= 1'b0;
         run_done                <= 1'b0;
         error                   <= 1'b0;
      end else begin
         state                  <= next_state;
         ptr                    <= ptr_d;
         nrows                  <= nrows_d;
         row                    <= row_d;
         cnt                    <= cnt_d;
         job_count              <= job_d;
         host_sram_write_enable <= wr_d;
         if (wr_d) begin
            host_sram_write_address <= ptr;
            host_sram_write_data    <= in_data;
         end
         dut_run  <= (next_state == RUN);
         run_done <= (next_state == DONE);
         error    <= (next_state == ERR);
      end
   end
endmodule

// File: tb/tb_conv_job_loader.sv
// Randomized self-checking bench for conv_job_loader: a stream-parsing reference
// model predicts SRAM writes, job counts and errors; handshake timing is checked directly.
module tb_conv_job_loader;
   localparam logic [15:0] END_W = 16'h00FF;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_b, start, in_valid, dut_busy;
   logic [15:0] in_data;

   logic        rdy_a, we_a, run_a, done_a, err_a;
   logic [11:0] addr_a;
   logic [15:0] data_a;
   logic [7:0]  job_a;
   logic        rdy_b, we_b, run_b, done_b, err_b;
   logic [2:0]  addr_b;
   logic [15:0] data_b;
   logic [7:0]  job_b;

   int          n_checks = 0;
   int          n_fail   = 0;
   wr_t         wq_a[$];
   wr_t         wq_b[$];
   int          run_cycles   = 0;
   int          run_with_end = 0;
   logic [15:0] stim_q[$];
   wr_t         exp_w[$];
   int          exp_acc, exp_jobs;
   bit          exp_err, exp_end;

   always #5 clk = ~clk;

   conv_job_loader u_dut (
      .clk(clk), .reset_b(reset_b), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy_a), .host_sram_write_address(addr_a), .host_sram_write_data(data_a),
      .host_sram_write_enable(we_a), .dut_run(run_a), .dut_busy(dut_busy),
      .job_count(job_a), .run_done(done_a), .error(err_a)
   );

   conv_job_loader #(.ADDR_W(3)) u_ovf (
      .clk(clk), .reset_b(reset_b), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy_b), .host_sram_write_address(addr_b), .host_sram_write_data(data_b),
      .host_sram_write_enable(we_b), .dut_run(run_b), .dut_busy(dut_busy),
      .job_count(job_b), .run_done(done_b), .error(err_b)
   );

   // Record every SRAM write and every dut_run cycle
   always @(negedge clk) begin
      if (we_a) wq_a.push_back('{int'(addr_a), int'(data_a)});
      if (we_b) wq_b.push_back('{int'(addr_b), int'(data_b)});
      if (run_a) begin
         run_cycles++;
         if (we_a && data_a == END_W) run_with_end++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: parse the stream by its framing rules into the expected write list
   function automatic void model(input int depth);
      int ptr, phase, left, w;
      ptr = 0; phase = 0; left = 0;
      exp_w.delete();
      exp_acc = 0; exp_jobs = 0; exp_err = 0; exp_end = 0;
      for (int i = 0; i < stim_q.size(); i++) begin
         w = int'(stim_q[i]);
         exp_acc++;
         if (phase == 0 && w == 'hFF) begin
            exp_w.push_back('{ptr, w});
            exp_end = 1;
            break;
         end
         if (phase < 2 && (w == 0 || w > 16)) begin
            exp_err = 1;
            break;
         end
         exp_w.push_back('{ptr, w});
         if (ptr == depth - 1) begin
            exp_err = 1;
            break;
         end
         ptr++;
         if (phase == 0) begin
            left  = w;
            phase = 1;
         end else if (phase == 1) begin
            phase = 2;
         end else begin
            left--;
            if (left == 0) begin
               exp_jobs++;
               phase = 0;
            end
         end
      end
   endfunction

   function automatic void build_random(input bit bad);
      int njobs, r, c, jb;
      bit bad_col;
      logic [15:0] badv;
      njobs   = $urandom_range(3, 1);
      jb      = $urandom_range(njobs - 1, 0);
      bad_col = $urandom_range(1, 0) != 0;
      badv    = ($urandom_range(1, 0) == 0) ? 16'h0000 : 16'($urandom_range(200, 17));
      stim_q.delete();
      for (int j = 0; j < njobs; j++) begin
         r = $urandom_range(4, 1);
         c = $urandom_range(16, 1);
         stim_q.push_back((bad && j == jb && !bad_col) ? badv : 16'(r));
         stim_q.push_back((bad && j == jb && bad_col) ? badv : 16'(c));
         for (int k = 0; k < r; k++) stim_q.push_back(16'($urandom));
      end
      stim_q.push_back(END_W);
   endfunction

   task automatic set_stim4(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
      stim_q.delete();
      stim_q.push_back(a); stim_q.push_back(b); stim_q.push_back(c); stim_q.push_back(d);
   endtask

   task automatic do_reset();
      reset_b = 1'b1;
      repeat (3) @(negedge clk);
      reset_b = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer stim_q words; mode 0 = always valid, 1 = every other cycle, 2 = random
   task automatic send_words(input bit sel, input int mode, input int budget, output int acc);
      int idx;
      bit v, rdy;
      idx = 0;
      acc = 0;
      for (int cyc = 0; cyc < budget && idx < stim_q.size(); cyc++) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2) == 0;
            default: v = $urandom_range(1, 0) != 0;
         endcase
         in_valid = v;
         in_data  = stim_q[idx];
         #1;
         rdy = sel ? rdy_b : rdy_a;
         @(posedge clk);
         if (v && rdy) begin
            idx++;
            acc++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic compare_writes(input string tag, input bit sel, input int base);
      int n;
      wr_t g;
      n = sel ? wq_b.size() - base : wq_a.size() - base;
      check({tag, "_nwr"}, n, exp_w.size());
      for (int i = 0; i < exp_w.size() && i < n; i++) begin
         g = sel ? wq_b[base + i] : wq_a[base + i];
         check({tag, "_addr"}, g.addr, exp_w[i].addr);
         check({tag, "_data"}, g.data, exp_w[i].data);
      end
   endtask

   task automatic run_case(input string tag, input int mode);
      int acc, wbase, rbase, ebase, k;
      model(4096);
      wbase = wq_a.size();
      rbase = run_cycles;
      ebase = run_with_end;
      pulse_start();
      check({tag, "_clr"}, 32'({job_a, done_a, err_a}), 0);
      send_words(1'b0, mode, 200, acc);
      check({tag, "_acc"}, acc, exp_acc);
      if (exp_end) begin
         check({tag, "_run"}, run_a, 1);
         @(negedge clk);
         dut_busy = 1'b1;
         for (k = 0; k < 10; k++) begin
            start = (k == 3);
            @(negedge clk);
         end
         start    = 1'b0;
         dut_busy = 1'b0;
         for (k = 0; k < 8 && !done_a; k++) @(negedge clk);
         check({tag, "_done"}, done_a, 1);
         check({tag, "_run_cycles"}, run_cycles - rbase, 1);
         check({tag, "_run_with_end"}, run_with_end - ebase, 1);
      end else begin
         repeat (2) @(negedge clk);
         check({tag, "_rdy"}, rdy_a, 0);
      end
      check({tag, "_err"}, err_a, exp_err);
      compare_writes(tag, 1'b0, wbase);
      check({tag, "_jobs"}, job_a, exp_jobs);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int acc, first, wbase;
      logic e200;
      start = 0; in_valid = 0; in_data = 0; dut_busy = 0; reset_b = 0;
      @(negedge clk);
      do_reset();
      check("rst_rdy", rdy_a, 0);
      check("rst_wr", 32'({we_a, addr_a, data_a}), 0);
      check("rst_ctl", 32'({run_a, job_a, done_a, err_a}), 0);
      check("rst_ovf", 32'({rdy_b, we_b, err_b}), 0);

      // Directed 3x3 job, then two jobs back to back from DONE
      stim_q.delete();
      stim_q.push_back(16'd3); stim_q.push_back(16'd3); stim_q.push_back(16'h0007);
      stim_q.push_back(16'h0005); stim_q.push_back(16'h0007); stim_q.push_back(END_W);
      run_case("job3x3", 0);
      stim_q.delete();
      stim_q.push_back(16'd1); stim_q.push_back(16'd1); stim_q.push_back(16'h1234);
      stim_q.push_back(16'd2); stim_q.push_back(16'd1); stim_q.push_back(16'h00FF);
      stim_q.push_back(16'hBEEF); stim_q.push_back(END_W);
      run_case("restart", 0);

      build_random(1'b0);
      run_case("backpressure", 1);

      set_stim4(16'd0, 16'd3, 16'd3, END_W);
      run_case("bad_nrows", 0);
      set_stim4(16'd2, 16'd17, 16'd1, END_W);
      run_case("bad_ncols", 0);

      // No busy response after dut_run
      set_stim4(16'd1, 16'd1, 16'd5, END_W);
      pulse_start();
      send_words(1'b0, 0, 50, acc);
      check("to_run", run_a, 1);
      first = -1;
      e200  = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (k == 200) e200 = err_a;
         if (err_a) begin
            first = k;
            break;
         end
      end
      check("to_early", e200, 0);
      check("to_window", (first >= 255 && first <= 258), 1);
      check("to_done", done_a, 0);

      // Reset while the second row word is offered
      stim_q.delete();
      stim_q.push_back(16'd2); stim_q.push_back(16'd2); stim_q.push_back(16'h00AA);
      pulse_start();
      send_words(1'b0, 0, 20, acc);
      in_valid = 1'b1;
      in_data  = 16'h00BB;
      reset_b  = 1'b1;
      @(negedge clk);
      check("rstdata_rdy", rdy_a, 0);
      check("rstdata_wr", 32'({we_a, addr_a, data_a}), 0);
      check("rstdata_ctl", 32'({run_a, job_a, done_a, err_a}), 0);
      in_valid = 1'b0;
      reset_b  = 1'b0;
      @(negedge clk);

      // Overflow on the 8-entry instance: 9 words offered, none terminating
      stim_q.delete();
      stim_q.push_back(16'd2); stim_q.push_back(16'd2); stim_q.push_back(16'd1);
      stim_q.push_back(16'd2); stim_q.push_back(16'd2); stim_q.push_back(16'd2);
      stim_q.push_back(16'd3); stim_q.push_back(16'd4); stim_q.push_back(16'd2);
      model(8);
      wbase = wq_b.size();
      pulse_start();
      send_words(1'b1, 0, 30, acc);
      repeat (2) @(negedge clk);
      check("ovf_acc", acc, exp_acc);
      check("ovf_err", err_b, 1);
      check("ovf_rdy", rdy_b, 0);
      compare_writes("ovf", 1'b1, wbase);
      do_reset();

      stim_q.delete();
      stim_q.push_back(16'd3); stim_q.push_back(16'd3); stim_q.push_back(16'h0007);
      stim_q.push_back(16'h0005); stim_q.push_back(16'h0007); stim_q.push_back(END_W);
      run_case("reload", 0);

      for (int i = 0; i < 8; i++) begin
         build_random($urandom_range(3, 0) == 0);
         run_case($sformatf("rand%0d", i), $urandom_range(2, 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
